// File: rtl/dpi_stream_sequencer_if.sv
// Bundle for the packet byte stream, matcher-bank drive and per-packet result.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the input side; matcher and result sides are strobes.
interface dpi_stream_sequencer_if #(
   parameter int N_REGEX = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [7:0]         in_data;
   logic               in_sop;
   logic               in_eop;
   logic [5:0]         in_stream_id;
   logic               load_state;
   logic [5:0]         stream_id;
   logic               new_stream_id;
   logic [7:0]         char_in;
   logic               char_in_vld;
   logic               eop;
   logic [N_REGEX-1:0] enable;
   logic [N_REGEX-1:0] fired;
   logic               res_valid;
   logic [5:0]         res_stream_id;
   logic [N_REGEX-1:0] res_match;

   // Sequencer side
   modport master (
      input  in_valid, in_data, in_sop, in_eop, in_stream_id, fired,
      output in_ready, load_state, stream_id, new_stream_id, char_in, char_in_vld,
             eop, enable, res_valid, res_stream_id, res_match
   );

   // Parser / matcher bank / result consumer side
   modport slave (
      output in_valid, in_data, in_sop, in_eop, in_stream_id, fired,
      input  in_ready, load_state, stream_id, new_stream_id, char_in, char_in_vld,
             eop, enable, res_valid, res_stream_id, res_match
   );
endinterface

// File: rtl/dpi_stream_sequencer.sv
// Sequences one packet at a time into a bank of per-stream regex matchers and reports matches.
// Latency: byte to char_in 1 cycle; load_state to first byte >= LOAD_WAIT+1; last char to eop DRAIN.
// Backpressure: sop held until the matchers are loaded; STREAM always ready. DPI_SEQ_WATCHDOG_EN adds a stall watchdog.
module dpi_stream_sequencer #(
   parameter int N_REGEX   = 8,
   parameter int LOAD_WAIT = 2,
   parameter int DRAIN     = 3
`ifdef DPI_SEQ_WATCHDOG_EN
   , parameter int WDOG_CYCLES = 1024
`endif
) (
   input  logic                   clk,
   input  logic                   rst_n,
   dpi_stream_sequencer_if.master bus,
   input  logic                   cfg_we,
   input  logic                   cfg_clr,
   input  logic [5:0]             cfg_addr,
   input  logic [N_REGEX-1:0]     cfg_mask,
   output logic [31:0]            pkt_cnt,
   output logic [15:0]            drop_cnt
`ifdef DPI_SEQ_WATCHDOG_EN
   , output logic                 wdog_err
`endif
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_WAIT, S_STREAM, S_DRAIN, S_EOP, S_REPORT
   } state_t;

   localparam logic [7:0] WAIT_LAST  = 8'(LOAD_WAIT - 1);
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN - 1);

   state_t             state, state_nxt;
   logic [7:0]         cnt;
   logic               in_ready_c;
   logic               accept;
   logic               wd_trip;

   logic [63:0]        seen;
   logic [N_REGEX-1:0] mask [64];

   logic               load_state_q, new_stream_q, char_vld_q, eop_q, res_valid_q;
   logic [5:0]         stream_id_q, res_id_q;
   logic [7:0]         char_q;
   logic [N_REGEX-1:0] enable_q, res_match_q;

`ifdef DPI_SEQ_WATCHDOG_EN
   localparam int             WW      = $clog2(WDOG_CYCLES + 1);
   localparam logic [WW-1:0]  WD_LAST = WW'(WDOG_CYCLES - 1);
   logic [WW-1:0]             wd_cnt;

   assign wd_trip = (state == S_STREAM) && !bus.in_valid && (wd_cnt == WD_LAST);

   // Count consecutive idle input cycles mid-packet; flag a stall sticky until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt   <= '0;
         wdog_err <= 1'b0;
      end else begin
         wd_cnt   <= ((state == S_STREAM) && !bus.in_valid) ? wd_cnt + 1'b1 : '0;
         wdog_err <= wdog_err | wd_trip;
      end
   end
`else
   assign wd_trip = 1'b0;
`endif

   assign accept = bus.in_valid & in_ready_c;

   // Next-state and input handshake
   always_comb begin
      state_nxt  = state;
      in_ready_c = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready_c = bus.in_valid & ~bus.in_sop;
            if (bus.in_valid && bus.in_sop) state_nxt = S_LOAD;
         end
         S_LOAD:   state_nxt = S_WAIT;
         S_WAIT:   if (cnt == WAIT_LAST) state_nxt = S_STREAM;
         S_STREAM: begin
            in_ready_c = 1'b1;
            if ((bus.in_valid && bus.in_eop) || wd_trip) state_nxt = S_DRAIN;
         end
         S_DRAIN:  if (cnt == DRAIN_LAST) state_nxt = S_EOP;
         S_EOP:    state_nxt = S_REPORT;
         S_REPORT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // State register and the shared WAIT/DRAIN phase counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= ((state_nxt == state) && (state == S_WAIT || state == S_DRAIN)) ? cnt + 8'd1 : '0;
      end
   end

   // Stream table: config writes and the seen set on load; a clear to the same entry wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen <= '0;
         for (int i = 0; i < 64; i++) mask[i] <= '1;
      end else begin
         if (cfg_we) mask[cfg_addr] <= cfg_mask;
         if (state == S_LOAD) seen[stream_id_q] <= 1'b1;
         if (cfg_clr) seen[cfg_addr] <= 1'b0;
      end
   end

   // Registered matcher drive, packet context, result and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_state_q <= 1'b0;
         new_stream_q <= 1'b0;
         stream_id_q  <= '0;
         enable_q     <= '0;
         char_q       <= '0;
         char_vld_q   <= 1'b0;
         eop_q        <= 1'b0;
         res_valid_q  <= 1'b0;
         res_id_q     <= '0;
         res_match_q  <= '0;
         pkt_cnt      <= '0;
         drop_cnt     <= '0;
      end else begin
         load_state_q <= (state_nxt == S_LOAD);
         eop_q        <= (state_nxt == S_EOP);
         res_valid_q  <= (state_nxt == S_REPORT);
         char_vld_q   <= (state == S_STREAM) && accept;
         if ((state == S_STREAM) && accept) char_q <= bus.in_data;
         // Latch the packet context on the held sop; a clear landing this cycle still counts
         if ((state == S_IDLE) && (state_nxt == S_LOAD)) begin
            stream_id_q  <= bus.in_stream_id;
            enable_q     <= mask[bus.in_stream_id];
            new_stream_q <= ~seen[bus.in_stream_id] | (cfg_clr & (cfg_addr == bus.in_stream_id));
         end else if (state_nxt == S_IDLE) begin
            stream_id_q  <= '0;
            enable_q     <= '0;
            new_stream_q <= 1'b0;
         end
         if (state_nxt == S_REPORT) begin
            res_id_q    <= stream_id_q;
            res_match_q <= bus.fired & enable_q;
            pkt_cnt     <= pkt_cnt + 32'd1;
         end
         if ((state == S_IDLE) && accept && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

   assign bus.in_ready      = in_ready_c;
   assign bus.load_state    = load_state_q;
   assign bus.stream_id     = stream_id_q;
   assign bus.new_stream_id = new_stream_q;
   assign bus.char_in       = char_q;
   assign bus.char_in_vld   = char_vld_q;
   assign bus.eop           = eop_q;
   assign bus.enable        = enable_q;
   assign bus.res_valid     = res_valid_q;
   assign bus.res_stream_id = res_id_q;
   assign bus.res_match     = res_match_q;
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Bench for dpi_stream_sequencer: directed packets, expectations queued at issue time.
// A negedge monitor pops and compares on every load_state, char_in_vld, eop and res_valid.
// Build with DPI_SEQ_WATCHDOG_EN to also exercise the stall watchdog (WDOG_CYCLES=16).
module tb_dpi_stream_sequencer;
   localparam int N  = 8;
   localparam int LW = 2;
   localparam int DR = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_we, cfg_clr;
   logic [5:0]    cfg_addr;
   logic [N-1:0]  cfg_mask;
   logic [31:0]   pkt_cnt;
   logic [15:0]   drop_cnt;
`ifdef DPI_SEQ_WATCHDOG_EN
   logic          wdog_err;
`endif

   always #5 clk = ~clk;

   dpi_stream_sequencer_if #(.N_REGEX(N)) sif();

   dpi_stream_sequencer #(
      .N_REGEX(N), .LOAD_WAIT(LW), .DRAIN(DR)
`ifdef DPI_SEQ_WATCHDOG_EN
      , .WDOG_CYCLES(16)
`endif
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (sif),
      .cfg_we   (cfg_we),
      .cfg_clr  (cfg_clr),
      .cfg_addr (cfg_addr),
      .cfg_mask (cfg_mask),
      .pkt_cnt  (pkt_cnt),
      .drop_cnt (drop_cnt)
`ifdef DPI_SEQ_WATCHDOG_EN
      , .wdog_err (wdog_err)
`endif
   );

   typedef struct { logic [5:0] id; logic nw; } load_t;
   typedef struct { logic [N-1:0] en; logic [5:0] id; bit chk_gap; } eop_t;
   typedef struct { logic [5:0] id; logic [N-1:0] m; logic [31:0] cnt; } res_t;

   load_t       exp_load[$];
   logic [7:0]  exp_char[$];
   eop_t        exp_eop[$];
   res_t        exp_res[$];

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   int          last_char_cyc = 0;
   int          last_eop_cyc  = 0;

   bit          tb_seen [64];
   logic [N-1:0] tb_mask [64];
   int          tb_pkts = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endfunction

   function automatic void unexp(input string nm);
      tests++;
      fails++;
      $display("FAIL %s: strobe seen with no expectation queued", nm);
   endfunction

   // Monitor: pops the scoreboard whenever the DUT presents an output strobe
   initial begin
      load_t l; eop_t e; res_t r; logic [7:0] c;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (sif.load_state) begin
               if (exp_load.size() == 0) unexp("load_state");
               else begin
                  l = exp_load.pop_front();
                  chk("load_stream_id", sif.stream_id, l.id);
                  chk("new_stream_id", sif.new_stream_id, l.nw);
               end
            end
            if (sif.char_in_vld) begin
               if (exp_char.size() == 0) unexp("char_in_vld");
               else begin
                  c = exp_char.pop_front();
                  chk("char_in", sif.char_in, c);
               end
               last_char_cyc = cyc;
            end
            if (sif.eop) begin
               if (exp_eop.size() == 0) unexp("eop");
               else begin
                  e = exp_eop.pop_front();
                  chk("eop_enable", sif.enable, e.en);
                  chk("eop_stream_id", sif.stream_id, e.id);
                  if (e.chk_gap) chk("eop_gap", cyc - last_char_cyc, DR);
               end
               last_eop_cyc = cyc;
            end
            if (sif.res_valid) begin
               if (exp_res.size() == 0) unexp("res_valid");
               else begin
                  r = exp_res.pop_front();
                  chk("res_stream_id", sif.res_stream_id, r.id);
                  chk("res_match", sif.res_match, r.m);
                  chk("pkt_cnt", pkt_cnt, r.cnt);
                  chk("res_gap", cyc - last_eop_cyc, 1);
               end
            end
         end
      end
   end

   // Hard stop if something wedges beyond every local bound
   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL global_timeout: cycle %0d reached, limit 20000", cyc);
      $fatal(1, "timeout");
   end

   function automatic int pending();
      return exp_load.size() + exp_char.size() + exp_eop.size() + exp_res.size();
   endfunction

   task automatic drive(input logic [7:0] d, input logic sop, input logic eopb,
                        input logic [5:0] id, output int waited);
      @(negedge clk);
      sif.in_valid = 1'b1; sif.in_data = d; sif.in_sop = sop;
      sif.in_eop = eopb; sif.in_stream_id = id;
      #1;
      waited = 0;
      while (!sif.in_ready && waited < 100) begin
         @(negedge clk); #1;
         waited++;
      end
      if (!sif.in_ready) chk("ready_timeout", sif.in_ready, 1);
      @(posedge clk); #1;
      sif.in_valid = 1'b0; sif.in_sop = 1'b0; sif.in_eop = 1'b0;
   endtask

   task automatic wait_quiet();
      int n = 0;
      while (pending() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("outstanding_expectations", pending(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [5:0] id, input string s, input bit gaps,
                           input logic [N-1:0] fired);
      int w;
      sif.fired = fired;
      exp_load.push_back('{id: id, nw: !tb_seen[id]});
      tb_seen[id] = 1'b1;
      for (int i = 0; i < s.len(); i++) exp_char.push_back(s[i]);
      tb_pkts++;
      exp_eop.push_back('{en: tb_mask[id], id: id, chk_gap: 1'b1});
      exp_res.push_back('{id: id, m: fired & tb_mask[id], cnt: tb_pkts});
      for (int i = 0; i < s.len(); i++) begin
         if (gaps && (i % 2 == 1)) @(negedge clk);
         drive(s[i], i == 0, i == s.len() - 1, id, w);
      end
      wait_quiet();
   endtask

   task automatic cfg_write(input logic [5:0] a, input logic [N-1:0] m);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_mask = m;
      @(negedge clk);
      cfg_we = 1'b0;
      tb_mask[a] = m;
   endtask

   task automatic cfg_clear(input logic [5:0] a);
      @(negedge clk);
      cfg_clr = 1'b1; cfg_addr = a;
      @(negedge clk);
      cfg_clr = 1'b0;
      tb_seen[a] = 1'b0;
   endtask

   task automatic reset_model();
      for (int i = 0; i < 64; i++) begin
         tb_seen[i] = 1'b0;
         tb_mask[i] = '1;
      end
      tb_pkts = 0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_load_state"}, sif.load_state, 0);
      chk({tag, "_char_in_vld"}, sif.char_in_vld, 0);
      chk({tag, "_eop"}, sif.eop, 0);
      chk({tag, "_enable"}, sif.enable, 0);
      chk({tag, "_res_valid"}, sif.res_valid, 0);
      chk({tag, "_stream_id"}, sif.stream_id, 0);
      chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
      chk({tag, "_drop_cnt"}, drop_cnt, 0);
   endtask

   initial begin
      int w;
      rst_n = 1'b0;
      sif.in_valid = 1'b0; sif.in_data = '0; sif.in_sop = 1'b0; sif.in_eop = 1'b0;
      sif.in_stream_id = '0; sif.fired = '0;
      cfg_we = 1'b0; cfg_clr = 1'b0; cfg_addr = '0; cfg_mask = '0;
      reset_model();

      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
`ifdef DPI_SEQ_WATCHDOG_EN
      chk("reset_wdog_err", wdog_err, 0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // New stream, then seen, then retired and new again (last one single-byte)
      send_pkt(6'd5, "abc", 1'b0, 8'h12);
      send_pkt(6'd5, "de", 1'b0, 8'h00);
      cfg_clear(6'd5);
      send_pkt(6'd5, "f", 1'b0, 8'hF0);

      // Restricted mask, all matchers firing, input valid toggling
      cfg_write(6'd9, 8'h05);
      send_pkt(6'd9, "0123", 1'b1, 8'hFF);

      // Non-sop beats in IDLE are accepted at once and dropped
      for (int i = 0; i < 3; i++) begin
         drive(8'hA0 + 8'(i), 1'b0, 1'b0, 6'd0, w);
         chk("drop_ready_wait", w, 0);
      end
      chk("drop_cnt", drop_cnt, 3);

`ifdef DPI_SEQ_WATCHDOG_EN
      // Stall mid-packet until the watchdog forces eop; the tail is dropped later
      sif.fired = 8'h3C;
      exp_load.push_back('{id: 6'd2, nw: !tb_seen[2]});
      tb_seen[2] = 1'b1;
      exp_char.push_back(8'h77);
      tb_pkts++;
      exp_eop.push_back('{en: tb_mask[2], id: 6'd2, chk_gap: 1'b0});
      exp_res.push_back('{id: 6'd2, m: 8'h3C & tb_mask[2], cnt: tb_pkts});
      drive(8'h77, 1'b1, 1'b0, 6'd2, w);
      wait_quiet();
      chk("wdog_err", wdog_err, 1);
      drive(8'h71, 1'b0, 1'b0, 6'd2, w);
      chk("wdog_tail_ready_wait", w, 0);
      drive(8'h72, 1'b0, 1'b1, 6'd2, w);
      chk("wdog_tail_drop_cnt", drop_cnt, 5);
`endif

      // Reset in the middle of a packet on an already-seen stream
      exp_load.push_back('{id: 6'd5, nw: !tb_seen[5]});
      exp_char.push_back(8'h78);
      exp_char.push_back(8'h79);
      drive(8'h78, 1'b1, 1'b0, 6'd5, w);
      drive(8'h79, 1'b0, 1'b0, 6'd5, w);
      w = 0;
      while (exp_char.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("pre_reset_chars_left", exp_char.size(), 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("midpkt_reset");
      exp_load.delete(); exp_char.delete(); exp_eop.delete(); exp_res.delete();
      reset_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send_pkt(6'd5, "z", 1'b0, 8'h81);
      repeat (5) @(negedge clk);

      chk("final_outstanding", pending(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
